// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: fetches operands from a 4x8 register file, drives the ALU
// from registers, then commits the ALU result and flags on the edge leaving EXEC.
module alu_exec_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       load_en,
    input  logic [1:0] load_addr,
    input  logic [7:0] load_data,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [2:0] alu_mode,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       done,
    output logic       illegal,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic [7:0] in1_q, in1_d, in2_q, in2_d;
    logic [2:0] mode_q, mode_d;
    logic [1:0] rd_q, rd_d;
    logic       flag_zero_q, flag_zero_d, flag_carry_q, flag_carry_d;
    logic       done_q, done_d, illegal_q, illegal_d;

    assign instr_ready = (state_q == IDLE) && !load_en;
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_mode    = mode_q;
    assign flag_zero   = flag_zero_q;
    assign flag_carry  = flag_carry_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign dbg_data    = regs_q[dbg_addr];

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        mode_d       = mode_q;
        rd_d         = rd_q;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending load takes the cycle; the instruction is held off until it drops.
                if (load_en) begin
                    regs_d[load_addr] = load_data;
                end else if (instr_valid) begin
                    in1_d   = regs_q[instr[4:3]];
                    in2_d   = instr[0] ? {{6{instr[2]}}, instr[2:1]} : regs_q[instr[2:1]];
                    mode_d  = instr[7:5];
                    rd_d    = instr[4:3];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                done_d  = 1'b1;
                case (mode_q)
                    3'b000, 3'b001: begin
                        regs_d[rd_q] = alu_out;
                        flag_zero_d  = (alu_out == 8'h00);
                        flag_carry_d = alu_carry;
                    end
                    3'b010: begin
                        flag_zero_d  = alu_zero;
                        flag_carry_d = alu_carry;
                    end
                    3'b011, 3'b100, 3'b101: begin
                        regs_d[rd_q] = alu_out;
                        flag_zero_d  = (alu_out == 8'h00);
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_regfile
            always_ff @(posedge clk) begin
                if (reset) regs_q[gi] <= 8'h00;
                else       regs_q[gi] <= regs_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            in1_q        <= 8'h00;
            in2_q        <= 8'h00;
            mode_q       <= 3'b000;
            rd_q         <= 2'd0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            mode_q       <= mode_d;
            rd_q         <= rd_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
        end
    end
endmodule
